// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART blocks.
//   - uart_state_e : receiver/transmitter frame state (3 bits)
//   - UART_*_MIN/MAX : legal parameter ranges
//   - uart_parity() : parity-bit generator, shared with the transmitter
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  localparam int UART_DATA_BITS_MIN  = 5;
  localparam int UART_DATA_BITS_MAX  = 9;
  localparam int UART_OVERSAMPLE_MIN = 8;
  localparam int UART_OVERSAMPLE_MAX = 32;
  localparam int UART_STOP_BITS_MIN  = 1;
  localparam int UART_STOP_BITS_MAX  = 2;

  // Parity bit for a word zero-extended to the widest legal size (extra zeros
  // do not change the XOR). odd=0 gives the even-parity bit, odd=1 the odd one.
  function automatic logic uart_parity(input logic [UART_DATA_BITS_MAX-1:0] d,
                                       input logic                          odd);
    return (^d) ^ odd;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchroniser for a single asynchronous input.
// Ports:
//   i_clk  - destination clock
//   i_rst  - asynchronous active-high reset, flops load RST_VAL
//   i_d    - asynchronous input
//   o_q    - synchronised output (2 clk latency)
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/uart_rx_param.sv
// uart_rx_param: parametrised oversampling UART receiver.
// Ports:
//   clk        - system clock
//   reset      - asynchronous active-high reset
//   tick       - oversample strobe, OVERSAMPLE pulses per bit period
//   rx         - asynchronous serial line, idles high
//   data       - last received word
//   data_valid - data holds an unacknowledged word
//   data_ack   - consumer takes data, clears data_valid
//   parity_err - parity mismatch for the word in data
//   frame_err  - a stop bit was sampled low for the word in data
//   overrun    - 1-clk pulse when a new word replaced an unacknowledged one
//   busy       - receiver is inside a frame (state != IDLE)
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 data_valid,
  input  logic                 data_ack,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);

  localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);
  localparam logic          PAR_ODD   = (PARITY_ODD != 0);
  localparam logic          PAR_ON    = (PARITY_EN != 0);

  if (DATA_BITS < UART_DATA_BITS_MIN || DATA_BITS > UART_DATA_BITS_MAX) begin : g_bad_data_bits
    $fatal(1, "uart_rx_param: DATA_BITS=%0d out of range", DATA_BITS);
  end
  if (OVERSAMPLE < UART_OVERSAMPLE_MIN || OVERSAMPLE > UART_OVERSAMPLE_MAX ||
      (OVERSAMPLE % 2) != 0) begin : g_bad_oversample
    $fatal(1, "uart_rx_param: OVERSAMPLE=%0d illegal", OVERSAMPLE);
  end
  if (STOP_BITS < UART_STOP_BITS_MIN || STOP_BITS > UART_STOP_BITS_MAX) begin : g_bad_stop_bits
    $fatal(1, "uart_rx_param: STOP_BITS=%0d out of range", STOP_BITS);
  end
  if (PARITY_EN < 0 || PARITY_EN > 1 || PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_parity
    $fatal(1, "uart_rx_param: PARITY_EN/PARITY_ODD must be 0 or 1");
  end

  logic w_rx_s;

  sync_2ff #(.RST_VAL(1'b1)) u_sync (
    .i_clk (clk),
    .i_rst (reset),
    .i_d   (rx),
    .o_q   (w_rx_s)
  );

  uart_state_e          r_state,     w_state_nxt;
  logic [TW-1:0]        r_tick_cnt,  w_tick_cnt_nxt;
  logic [BW-1:0]        r_bit_cnt,   w_bit_cnt_nxt;
  logic [DATA_BITS-1:0] r_shift,     w_shift_nxt;
  logic                 r_par_bad,   w_par_bad_nxt;
  logic                 r_frame_bad, w_frame_bad_nxt;
  logic                 r_armed,     w_armed_nxt;
  logic                 w_done;
  logic                 w_tick_mid;
  logic                 w_tick_last;

  logic [DATA_BITS-1:0] r_data;
  logic                 r_valid;
  logic                 r_perr;
  logic                 r_ferr;
  logic                 r_ovr;

  assign w_tick_mid  = (r_tick_cnt == TICK_MID);
  assign w_tick_last = (r_tick_cnt == TICK_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_tick_cnt  <= '0;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_par_bad   <= 1'b0;
      r_frame_bad <= 1'b0;
      r_armed     <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_tick_cnt  <= w_tick_cnt_nxt;
      r_bit_cnt   <= w_bit_cnt_nxt;
      r_shift     <= w_shift_nxt;
      r_par_bad   <= w_par_bad_nxt;
      r_frame_bad <= w_frame_bad_nxt;
      r_armed     <= w_armed_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_tick_cnt_nxt  = r_tick_cnt;
    w_bit_cnt_nxt   = r_bit_cnt;
    w_shift_nxt     = r_shift;
    w_par_bad_nxt   = r_par_bad;
    w_frame_bad_nxt = r_frame_bad;
    w_armed_nxt     = r_armed;
    w_done          = 1'b0;
    case (r_state)
      IDLE: begin
        // armed only after the line has been seen high, so a held-low line
        // (break, or a false start still low) cannot retrigger a frame.
        if (w_rx_s) begin
          w_armed_nxt = 1'b1;
        end else if (r_armed) begin
          w_state_nxt    = START;
          w_tick_cnt_nxt = '0;
          w_bit_cnt_nxt  = '0;
          w_armed_nxt    = 1'b0;
        end
      end
      START: begin
        if (tick) begin
          if (w_tick_mid) begin
            w_tick_cnt_nxt = '0;
            w_bit_cnt_nxt  = '0;
            if (w_rx_s) begin
              w_state_nxt = IDLE;
            end else begin
              w_state_nxt     = DATA;
              w_par_bad_nxt   = 1'b0;
              w_frame_bad_nxt = 1'b0;
            end
          end else begin
            w_tick_cnt_nxt = r_tick_cnt + 1'b1;
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (w_tick_last) begin
            w_tick_cnt_nxt = '0;
            w_shift_nxt    = {w_rx_s, r_shift[DATA_BITS-1:1]};
            if (r_bit_cnt == BIT_LAST) begin
              w_bit_cnt_nxt = '0;
              if (PAR_ON) w_state_nxt = PARITY;
              else        w_state_nxt = STOP;
            end else begin
              w_bit_cnt_nxt = r_bit_cnt + 1'b1;
            end
          end else begin
            w_tick_cnt_nxt = r_tick_cnt + 1'b1;
          end
        end
      end
      PARITY: begin
        if (tick) begin
          if (w_tick_last) begin
            w_tick_cnt_nxt = '0;
            w_bit_cnt_nxt  = '0;
            w_par_bad_nxt  = uart_parity(UART_DATA_BITS_MAX'(r_shift), PAR_ODD) ^ w_rx_s;
            w_state_nxt    = STOP;
          end else begin
            w_tick_cnt_nxt = r_tick_cnt + 1'b1;
          end
        end
      end
      STOP: begin
        if (tick) begin
          if (w_tick_last) begin
            w_tick_cnt_nxt  = '0;
            w_frame_bad_nxt = r_frame_bad | ~w_rx_s;
            if (r_bit_cnt == STOP_LAST) begin
              // deliver mid stop bit and go idle now so a back-to-back
              // start bit is not missed
              w_done        = 1'b1;
              w_state_nxt   = IDLE;
              w_bit_cnt_nxt = '0;
            end else begin
              w_bit_cnt_nxt = r_bit_cnt + 1'b1;
            end
          end else begin
            w_tick_cnt_nxt = r_tick_cnt + 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Output holding register and valid/ack handshake. A completion always
  // wins over an ack in the same cycle; overrun only when the old word was
  // still pending and not being taken.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_perr  <= 1'b0;
      r_ferr  <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      r_ovr <= 1'b0;
      if (w_done) begin
        r_data  <= r_shift;
        r_valid <= 1'b1;
        r_perr  <= PAR_ON & r_par_bad;
        r_ferr  <= w_frame_bad_nxt;
        r_ovr   <= r_valid & ~data_ack;
      end else if (data_ack) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign data       = r_data;
  assign data_valid = r_valid;
  assign parity_err = r_perr;
  assign frame_err  = r_ferr;
  assign overrun    = r_ovr;
  assign busy       = (r_state != IDLE);

endmodule

// File: tb/tb_uart_rx_param.sv
// tb_uart_rx_param: self-checking bench for uart_rx_param. Three instances
// cover 8N1/16x, 7E1/8x and 8O2/8x. Fixed vectors, hand-written corner
// sequences and random frames checked against a frame-level model.
module tb_uart_rx_param;

  localparam int NI = 3;
  localparam int NB   [NI] = '{8, 7, 8};
  localparam int OS   [NI] = '{16, 8, 8};
  localparam int PEN  [NI] = '{0, 1, 1};
  localparam int PODD [NI] = '{0, 0, 1};
  localparam int SB   [NI] = '{1, 1, 2};

  typedef struct {
    int         k;
    logic [8:0] word;
    logic       pbit;
    logic       s1;
    logic       s2;
    logic [8:0] exp_data;
    logic       exp_perr;
    logic       exp_ferr;
  } vec_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic tick  = 1'b0;
  logic rx  [NI];
  logic ack [NI];

  logic [7:0]    d0;
  logic [6:0]    d1;
  logic [7:0]    d2;
  logic [8:0]    dat [NI];
  logic [NI-1:0] vld, perr, ferr, ovr, bsy;

  assign dat[0] = 9'(d0);
  assign dat[1] = 9'(d1);
  assign dat[2] = 9'(d2);

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  // tick every tdiv clocks
  int tdiv = 1;
  int tph  = 0;
  always @(posedge clk) begin
    if (tph >= tdiv - 1) begin
      tph  <= 0;
      tick <= 1'b1;
    end else begin
      tph  <= tph + 1;
      tick <= 1'b0;
    end
  end

  uart_rx_param #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u0 (
    .clk(clk), .reset(reset), .tick(tick), .rx(rx[0]), .data(d0), .data_valid(vld[0]),
    .data_ack(ack[0]), .parity_err(perr[0]), .frame_err(ferr[0]), .overrun(ovr[0]), .busy(bsy[0]));

  uart_rx_param #(.DATA_BITS(7), .OVERSAMPLE(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u1 (
    .clk(clk), .reset(reset), .tick(tick), .rx(rx[1]), .data(d1), .data_valid(vld[1]),
    .data_ack(ack[1]), .parity_err(perr[1]), .frame_err(ferr[1]), .overrun(ovr[1]), .busy(bsy[1]));

  uart_rx_param #(.DATA_BITS(8), .OVERSAMPLE(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)) u2 (
    .clk(clk), .reset(reset), .tick(tick), .rx(rx[2]), .data(d2), .data_valid(vld[2]),
    .data_ack(ack[2]), .parity_err(perr[2]), .frame_err(ferr[2]), .overrun(ovr[2]), .busy(bsy[2]));

  // event counters: valid rises, overrun cycles, busy cycles
  int rises [NI] = '{0, 0, 0};
  int ovrs  [NI] = '{0, 0, 0};
  int bcnt  [NI] = '{0, 0, 0};
  logic [NI-1:0] pv = '0;
  always @(negedge clk) begin
    for (int m = 0; m < NI; m++) begin
      if (vld[m] && !pv[m]) rises[m] <= rises[m] + 1;
      if (ovr[m])           ovrs[m]  <= ovrs[m] + 1;
      if (bsy[m])           bcnt[m]  <= bcnt[m] + 1;
    end
    pv <= vld;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", nm, act, exp);
    end
  endtask

  task automatic gap(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drive one whole frame on instance k. ack_at>=0 raises data_ack for exactly
  // the clock following negedge number ack_at. lat returns the negedge count
  // at which a data_valid rise was first seen (-1 if none).
  task automatic send(input int k, input logic [8:0] w, input logic pb, input logic s1,
                      input logic s2, input int ack_at, output int lat);
    logic [15:0] fb;
    int          n;
    int          c;
    logic        pvv;
    fb    = '0;
    fb[0] = 1'b0;
    n     = 1;
    for (int i = 0; i < NB[k]; i++) begin
      fb[n] = w[i];
      n++;
    end
    if (PEN[k] != 0) begin
      fb[n] = pb;
      n++;
    end
    fb[n] = s1;
    n++;
    if (SB[k] == 2) begin
      fb[n] = s2;
      n++;
    end
    c   = 0;
    lat = -1;
    pvv = vld[k];
    for (int b = 0; b < n; b++) begin
      rx[k] = fb[b];
      for (int j = 0; j < OS[k] * tdiv; j++) begin
        @(negedge clk);
        c++;
        if (lat < 0 && vld[k] && !pvv) lat = c;
        pvv = vld[k];
        if (c == ack_at)          ack[k] = 1'b1;
        else if (c == ack_at + 1) ack[k] = 1'b0;
      end
    end
    rx[k] = 1'b1;
  endtask

  task automatic do_ack(input int k, input string nm);
    @(negedge clk);
    ack[k] = 1'b1;
    @(negedge clk);
    ack[k] = 1'b0;
    chk({nm, " ack clears valid"}, 32'(vld[k]), 32'd0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: time limit reached, actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t       vt [9];
    int         k, lat, dmy, r0, o0, b0;
    logic [8:0] w, mask, ew;
    logic       pb, s1, s2, ep, ef;

    vt[0] = '{0, 9'h05A, 1'b0, 1'b1, 1'b1, 9'h05A, 1'b0, 1'b0};
    vt[1] = '{1, 9'h041, 1'b0, 1'b1, 1'b1, 9'h041, 1'b0, 1'b0};
    vt[2] = '{1, 9'h041, 1'b1, 1'b1, 1'b1, 9'h041, 1'b1, 1'b0};
    vt[3] = '{2, 9'h0C3, 1'b1, 1'b1, 1'b0, 9'h0C3, 1'b0, 1'b1};
    vt[4] = '{2, 9'h03C, 1'b1, 1'b1, 1'b1, 9'h03C, 1'b0, 1'b0};
    vt[5] = '{0, 9'h000, 1'b0, 1'b0, 1'b1, 9'h000, 1'b0, 1'b1};
    vt[6] = '{1, 9'h07F, 1'b1, 1'b0, 1'b1, 9'h07F, 1'b0, 1'b1};
    vt[7] = '{2, 9'h0A5, 1'b0, 1'b1, 1'b1, 9'h0A5, 1'b1, 1'b0};
    vt[8] = '{0, 9'h0FF, 1'b0, 1'b1, 1'b1, 9'h0FF, 1'b0, 1'b0};

    for (int m = 0; m < NI; m++) begin
      rx[m]  = 1'b1;
      ack[m] = 1'b0;
    end

    // reset state
    gap(3);
    chk("reset valid", 32'(vld), 32'd0);
    chk("reset perr", 32'(perr), 32'd0);
    chk("reset ferr", 32'(ferr), 32'd0);
    chk("reset overrun", 32'(ovr), 32'd0);
    chk("reset busy", 32'(bsy), 32'd0);
    for (int m = 0; m < NI; m++) chk($sformatf("reset data%0d", m), 32'(dat[m]), 32'd0);
    reset = 1'b0;
    gap(6);

    // fixed vectors
    for (int i = 0; i < 9; i++) begin
      k  = vt[i].k;
      b0 = bcnt[k];
      send(k, vt[i].word, vt[i].pbit, vt[i].s1, vt[i].s2, -1, dmy);
      chk($sformatf("vec%0d valid", i), 32'(vld[k]), 32'd1);
      chk($sformatf("vec%0d data", i), 32'(dat[k]), 32'(vt[i].exp_data));
      chk($sformatf("vec%0d perr", i), 32'(perr[k]), 32'(vt[i].exp_perr));
      chk($sformatf("vec%0d ferr", i), 32'(ferr[k]), 32'(vt[i].exp_ferr));
      chk($sformatf("vec%0d busy idle", i), 32'(bsy[k]), 32'd0);
      chk($sformatf("vec%0d busy seen", i), 32'(bcnt[k] > b0), 32'd1);
      do_ack(k, $sformatf("vec%0d", i));
      gap(8);
    end

    // false start: 5-tick low glitch on 8N1
    r0 = rises[0];
    @(negedge clk);
    rx[0] = 1'b0;
    gap(5);
    rx[0] = 1'b1;
    gap(1);
    chk("false start busy", 32'(bsy[0]), 32'd1);
    gap(8);
    chk("false start back idle", 32'(bsy[0]), 32'd0);
    gap(10);
    chk("false start no valid", 32'(vld[0]), 32'd0);
    chk("false start no word", 32'(rises[0] - r0), 32'd0);

    // break: line held low, then must not restart until high again
    @(negedge clk);
    rx[0] = 1'b0;
    gap(12 * 16);
    chk("break valid", 32'(vld[0]), 32'd1);
    chk("break data", 32'(dat[0]), 32'd0);
    chk("break ferr", 32'(ferr[0]), 32'd1);
    chk("break busy", 32'(bsy[0]), 32'd0);
    b0 = bcnt[0];
    gap(48);
    chk("break no restart", 32'(bcnt[0] - b0), 32'd0);
    rx[0] = 1'b1;
    gap(8);
    do_ack(0, "break");
    gap(4);
    send(0, 9'h096, 1'b0, 1'b1, 1'b1, -1, dmy);
    chk("after break data", 32'(dat[0]), 32'h96);
    chk("after break ferr", 32'(ferr[0]), 32'd0);
    do_ack(0, "after break");
    gap(8);

    // back-to-back with and without ack on the completion cycle
    o0 = ovrs[0];
    send(0, 9'h011, 1'b0, 1'b1, 1'b1, -1, lat);
    chk("b2b latency found", 32'(lat > 0), 32'd1);
    send(0, 9'h022, 1'b0, 1'b1, 1'b1, -1, dmy);
    gap(2);
    chk("b2b data", 32'(dat[0]), 32'h22);
    chk("b2b valid", 32'(vld[0]), 32'd1);
    chk("b2b overrun count", 32'(ovrs[0] - o0), 32'd1);
    o0 = ovrs[0];
    send(0, 9'h033, 1'b0, 1'b1, 1'b1, lat - 1, dmy);
    gap(2);
    chk("ack-on-done data", 32'(dat[0]), 32'h33);
    chk("ack-on-done valid", 32'(vld[0]), 32'd1);
    chk("ack-on-done no overrun", 32'(ovrs[0] - o0), 32'd0);
    do_ack(0, "b2b");
    gap(8);

    // reset in the middle of data bit 4 of 0xFF
    r0 = rises[0];
    @(negedge clk);
    rx[0] = 1'b0;
    gap(16);
    rx[0] = 1'b1;
    gap(4 * 16 + 8);
    reset = 1'b1;
    gap(2);
    chk("mid reset valid", 32'(vld), 32'd0);
    chk("mid reset busy", 32'(bsy), 32'd0);
    reset = 1'b0;
    gap(20);
    send(0, 9'h00F, 1'b0, 1'b1, 1'b1, -1, dmy);
    gap(4);
    chk("mid reset single word", 32'(rises[0] - r0), 32'd1);
    chk("mid reset data", 32'(dat[0]), 32'h0F);
    do_ack(0, "mid reset");

    // random frames vs frame-level model
    for (int it = 0; it < 24; it++) begin
      k    = int'($urandom_range(0, NI - 1));
      tdiv = int'($urandom_range(1, 2));
      w    = 9'($urandom);
      pb   = 1'($urandom);
      s1   = ($urandom_range(0, 4) != 0);
      s2   = ($urandom_range(0, 4) != 0);
      mask = 9'((1 << NB[k]) - 1);
      ew   = w & mask;
      ep   = (PEN[k] != 0) && ((($countones(ew) + int'(pb)) % 2) != PODD[k]);
      ef   = !s1 || (SB[k] == 2 && !s2);
      gap(int'($urandom_range(4, 20)));
      send(k, w, pb, s1, s2, -1, dmy);
      chk($sformatf("rnd%0d valid", it), 32'(vld[k]), 32'd1);
      chk($sformatf("rnd%0d data", it), 32'(dat[k]), 32'(ew));
      chk($sformatf("rnd%0d perr", it), 32'(perr[k]), 32'(ep));
      chk($sformatf("rnd%0d ferr", it), 32'(ferr[k]), 32'(ef));
      do_ack(k, $sformatf("rnd%0d", it));
    end

    gap(4);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
